// File: rtl/tomasula_types.sv
// Shared types for the Tomasulo issue path: dispatch word, ALU issue word and opcodes.
package tomasula_types;

    localparam int ROB_TAG_W = 3;

    typedef enum logic [6:0] {
        OP_ALU    = 7'b0110011,
        OP_ALUI   = 7'b0010011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_BRANCH = 7'b1100011
    } op_t;

    typedef struct packed {
        op_t                  op;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [ROB_TAG_W-1:0] src1_tag;
        logic [31:0]          src1_data;
        logic                 src1_valid;
        logic [ROB_TAG_W-1:0] src2_tag;
        logic [31:0]          src2_data;
        logic                 src2_valid;
        logic [ROB_TAG_W-1:0] rd_tag;
        logic [31:0]          pc;
    } res_word;

    typedef struct packed {
        op_t                  op;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [31:0]          src1_data;
        logic [31:0]          src2_data;
        logic [31:0]          pc;
        logic [ROB_TAG_W-1:0] tag;
    } alu_word;

    function automatic alu_word to_alu(input res_word w);
        alu_word a;
        a.op        = w.op;
        a.funct3    = w.funct3;
        a.funct7    = w.funct7;
        a.src1_data = w.src1_data;
        a.src2_data = w.src2_data;
        a.pc        = w.pc;
        a.tag       = w.rd_tag;
        return a;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station: picks the oldest ready entry as a one-hot select.
module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] set,
    input  logic [DEPTH-1:0] clear,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] oldest
);

    // age[i][j] = 1 means entry i was allocated before entry j
    logic [DEPTH-1:0] age [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (set[i] || clear[i]) begin
                        age[i][j] <= 1'b0;
                    end else if (set[j]) begin
                        age[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    // Stale bits of freed entries are harmless: freed entries are never ready.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && age[j][i]) begin
                    oldest[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops, wakes operands from the CDB, issues oldest ready.
module reservation_station
    import tomasula_types::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = ROB_TAG_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  res_word                          disp_word,
    input  logic [NUM_CDB-1:0]               cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB-1:0][31:0]         cdb_data,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output alu_word                          iss_word,
    output logic [$clog2(DEPTH):0]           occupancy
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    // Operand slots: two per entry, plus the two operands of the incoming dispatch word.
    localparam int NOPS  = 2 * (DEPTH + 1);

    logic [DEPTH-1:0] valid;
    res_word          ent [DEPTH];

    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] free_oh;
    logic [DEPTH-1:0] sel;
    logic [DEPTH-1:0] age_set;
    logic [DEPTH-1:0] age_clear;
    logic             disp_fire;
    logic             iss_fire;
    res_word          disp_byp;

    logic [TAG_W-1:0]       op_tag [NOPS];
    logic [NOPS-1:0]        wake_hit;
    logic [NOPS-1:0][31:0]  wake_data;

    // Both ports use valid/ready: a transfer happens on a rising edge where valid and
    // ready are both 1; ready and valid depend only on registered state.
    assign disp_ready = ~&valid;
    assign disp_fire  = disp_valid && disp_ready;
    assign iss_valid  = |ready_vec;
    assign iss_fire   = iss_valid && iss_ready;

    // Lowest clear bit of valid is the allocation target.
    assign free_oh = ~valid & (valid + DEPTH'(1));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = valid[i] && ent[i].src1_valid && ent[i].src2_valid;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            op_tag[2*i]   = ent[i].src1_tag;
            op_tag[2*i+1] = ent[i].src2_tag;
        end
        op_tag[2*DEPTH]   = disp_word.src1_tag;
        op_tag[2*DEPTH+1] = disp_word.src2_tag;
    end

    for (genvar k = 0; k < NOPS; k++) begin : g_cdb_match
        logic        hit;
        logic [31:0] data;
        // Scan high to low so the lowest-numbered matching lane is the one that sticks.
        always_comb begin
            hit  = 1'b0;
            data = '0;
            for (int l = NUM_CDB - 1; l >= 0; l--) begin
                if (cdb_valid[l] && cdb_tag[l] == op_tag[k]) begin
                    hit  = 1'b1;
                    data = cdb_data[l];
                end
            end
        end
        assign wake_hit[k]  = hit;
        assign wake_data[k] = data;
    end

    always_comb begin
        disp_byp = disp_word;
        if (!disp_word.src1_valid && wake_hit[2*DEPTH]) begin
            disp_byp.src1_valid = 1'b1;
            disp_byp.src1_data  = wake_data[2*DEPTH];
        end
        if (!disp_word.src2_valid && wake_hit[2*DEPTH+1]) begin
            disp_byp.src2_valid = 1'b1;
            disp_byp.src2_data  = wake_data[2*DEPTH+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (iss_fire && sel[i]) begin
                    valid[i] <= 1'b0;
                end
                if (disp_fire && free_oh[i]) begin
                    valid[i] <= 1'b1;
                end
            end
        end
    end

    // Payload carries no reset; valid gates every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!flush && disp_fire && free_oh[i]) begin
                ent[i] <= disp_byp;
            end else if (!flush && valid[i]) begin
                if (!ent[i].src1_valid && wake_hit[2*i]) begin
                    ent[i].src1_valid <= 1'b1;
                    ent[i].src1_data  <= wake_data[2*i];
                end
                if (!ent[i].src2_valid && wake_hit[2*i+1]) begin
                    ent[i].src2_valid <= 1'b1;
                    ent[i].src2_data  <= wake_data[2*i+1];
                end
            end
        end
    end

    assign age_set   = (disp_fire && !flush) ? free_oh : '0;
    assign age_clear = flush ? '1 : (iss_fire ? sel : '0);

    rs_age_matrix #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk    (clk),
        .rst_n  (rst_n),
        .set    (age_set),
        .clear  (age_clear),
        .ready  (ready_vec),
        .oldest (sel)
    );

    always_comb begin
        iss_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                iss_word = to_alu(ent[i]);
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic against a queue model.
module tb_reservation_station;
    import tomasula_types::*;

    localparam int DEPTH   = 4;
    localparam int NUM_CDB = 2;
    localparam int TAG_W   = ROB_TAG_W;
    localparam int OCC_W   = $clog2(DEPTH) + 1;
    localparam int RW      = $bits(res_word);

    logic                          clk;
    logic                          rst_n;
    logic                          flush;
    logic                          disp_valid;
    logic                          disp_ready;
    res_word                       disp_word;
    logic [NUM_CDB-1:0]            cdb_valid;
    logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag;
    logic [NUM_CDB-1:0][31:0]      cdb_data;
    logic                          iss_valid;
    logic                          iss_ready;
    alu_word                       iss_word;
    logic [OCC_W-1:0]              occupancy;

    reservation_station #(
        .DEPTH   (DEPTH),
        .NUM_CDB (NUM_CDB),
        .TAG_W   (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_word  (disp_word),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_word   (iss_word),
        .occupancy  (occupancy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard: live entries, oldest first
    logic [RW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_word apply_cdb(input res_word w);
        res_word r;
        bit      got1;
        bit      got2;
        r    = w;
        got1 = r.src1_valid;
        got2 = r.src2_valid;
        for (int l = 0; l < NUM_CDB; l++) begin
            if (cdb_valid[l]) begin
                if (!got1 && cdb_tag[l] == r.src1_tag) begin
                    r.src1_valid = 1'b1;
                    r.src1_data  = cdb_data[l];
                    got1 = 1'b1;
                end
                if (!got2 && cdb_tag[l] == r.src2_tag) begin
                    r.src2_valid = 1'b1;
                    r.src2_data  = cdb_data[l];
                    got2 = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic int first_ready();
        res_word w;
        for (int i = 0; i < exp_q.size(); i++) begin
            w = res_word'(exp_q[i]);
            if (w.src1_valid && w.src2_valid) return i;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int      f;
        res_word w;
        alu_word a;
        f = first_ready();
        check("occupancy", 128'(occupancy), 128'(exp_q.size()));
        check("disp_ready", 128'(disp_ready), 128'(exp_q.size() < DEPTH));
        check("iss_valid", 128'(iss_valid), 128'(f >= 0));
        if (f >= 0) begin
            w = res_word'(exp_q[f]);
            a.op        = w.op;
            a.funct3    = w.funct3;
            a.funct7    = w.funct7;
            a.src1_data = w.src1_data;
            a.src2_data = w.src2_data;
            a.pc        = w.pc;
            a.tag       = w.rd_tag;
            check("iss_word", 128'(iss_word), 128'(a));
        end
    endtask

    task automatic model_step();
        int f;
        bit acc;
        if (flush) begin
            exp_q.delete();
        end else begin
            f   = first_ready();
            acc = disp_valid && (exp_q.size() < DEPTH);
            if (iss_ready && f >= 0) exp_q.delete(f);
            for (int i = 0; i < exp_q.size(); i++) begin
                exp_q[i] = RW'(apply_cdb(res_word'(exp_q[i])));
            end
            if (acc) exp_q.push_back(RW'(apply_cdb(disp_word)));
        end
    endtask

    // driver tasks
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        disp_valid = 1'b0;
        disp_word  = '0;
        cdb_valid  = '0;
        cdb_tag    = '0;
        cdb_data   = '0;
        iss_ready  = 1'b0;
    endtask

    task automatic drive_disp(input res_word w);
        disp_valid = 1'b1;
        disp_word  = w;
    endtask

    task automatic drive_cdb(input int lane, input logic [TAG_W-1:0] t, input logic [31:0] d);
        cdb_valid[lane] = 1'b1;
        cdb_tag[lane]   = t;
        cdb_data[lane]  = d;
    endtask

    function automatic res_word mk(input logic [2:0] rd,
                                   input bit v1, input logic [2:0] t1, input logic [31:0] d1,
                                   input bit v2, input logic [2:0] t2, input logic [31:0] d2);
        res_word w;
        w.op         = OP_ALU;
        w.funct3     = rd;
        w.funct7     = 7'h20;
        w.src1_valid = v1;
        w.src1_tag   = t1;
        w.src1_data  = d1;
        w.src2_valid = v2;
        w.src2_tag   = t2;
        w.src2_data  = d2;
        w.rd_tag     = rd;
        w.pc         = 32'h1000 + {27'b0, rd, 2'b0};
        return w;
    endfunction

    function automatic res_word rand_word();
        op_t     ops[5];
        res_word w;
        ops[0] = OP_ALU; ops[1] = OP_ALUI; ops[2] = OP_LUI; ops[3] = OP_AUIPC; ops[4] = OP_BRANCH;
        w.op         = ops[$urandom_range(0, 4)];
        w.funct3     = 3'($urandom);
        w.funct7     = 7'($urandom);
        w.src1_valid = 1'($urandom_range(0, 1));
        w.src1_tag   = 3'($urandom);
        w.src1_data  = $urandom;
        w.src2_valid = 1'($urandom_range(0, 1));
        w.src2_tag   = 3'($urandom);
        w.src2_data  = $urandom;
        w.rd_tag     = 3'($urandom);
        w.pc         = $urandom;
        return w;
    endfunction

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_iss_valid", 128'(iss_valid), 128'(0));
        check("rst_disp_ready", 128'(disp_ready), 128'(1));
        check("rst_occupancy", 128'(occupancy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fill to capacity with ready words while the ALU stalls
        for (int i = 1; i <= DEPTH; i++) begin
            drive_disp(mk(3'(i), 1, 3'd0, 32'(i * 16), 1, 3'd0, 32'(i * 256)));
            cycle();
        end
        check("full_disp_ready", 128'(disp_ready), 128'(0));
        check("full_occupancy", 128'(occupancy), 128'(4));
        check("full_oldest_tag", 128'(iss_word.tag), 128'(1));

        // full: issue frees an entry but the same-cycle dispatch is refused
        drive_disp(mk(3'd7, 1, 3'd0, 32'h7, 1, 3'd0, 32'h7));
        iss_ready = 1'b1;
        cycle();
        idle_inputs();
        check("full_iss_occ", 128'(occupancy), 128'(3));
        check("full_iss_next_tag", 128'(iss_word.tag), 128'(2));

        // flush beats concurrent dispatch, issue and CDB
        flush     = 1'b1;
        iss_ready = 1'b1;
        drive_disp(mk(3'd6, 0, 3'd5, 32'h0, 1, 3'd0, 32'h1));
        drive_cdb(0, 3'd5, 32'h55);
        cycle();
        idle_inputs();
        check("flush_occ", 128'(occupancy), 128'(0));
        check("flush_iss_valid", 128'(iss_valid), 128'(0));
        check("flush_disp_ready", 128'(disp_ready), 128'(1));

        // age order: A waits on tag 5, B is ready; B goes first, A after its wake-up
        drive_disp(mk(3'd1, 0, 3'd5, 32'h0, 1, 3'd0, 32'h11));
        cycle();
        drive_disp(mk(3'd2, 1, 3'd0, 32'h22, 1, 3'd0, 32'h33));
        cycle();
        idle_inputs();
        drive_cdb(1, 3'd5, 32'hDEADBEEF);
        iss_ready = 1'b1;
        check("age_first_tag", 128'(iss_word.tag), 128'(2));
        cycle();
        cdb_valid = '0;
        check("age_second_valid", 128'(iss_valid), 128'(1));
        check("age_second_tag", 128'(iss_word.tag), 128'(1));
        check("age_second_src1", 128'(iss_word.src1_data), 128'(32'hDEADBEEF));
        cycle();
        idle_inputs();

        // dispatch bypass from a same-cycle broadcast
        drive_disp(mk(3'd3, 1, 3'd0, 32'h44, 0, 3'd2, 32'h0));
        drive_cdb(0, 3'd2, 32'h12);
        cycle();
        idle_inputs();
        check("bypass_iss_valid", 128'(iss_valid), 128'(1));
        check("bypass_src2", 128'(iss_word.src2_data), 128'(32'h12));
        iss_ready = 1'b1;
        cycle();
        idle_inputs();

        // two lanes hit the same tag: lane 0 wins
        drive_disp(mk(3'd4, 0, 3'd3, 32'h0, 1, 3'd0, 32'h66));
        cycle();
        idle_inputs();
        drive_cdb(0, 3'd3, 32'h1);
        drive_cdb(1, 3'd3, 32'h2);
        cycle();
        idle_inputs();
        check("lane_prio_src1", 128'(iss_word.src1_data), 128'(32'h1));
        iss_ready = 1'b1;
        cycle();
        idle_inputs();

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            flush      = ($urandom_range(0, 63) == 0);
            disp_valid = ($urandom_range(0, 2) != 0);
            disp_word  = rand_word();
            for (int l = 0; l < NUM_CDB; l++) begin
                cdb_valid[l] = ($urandom_range(0, 2) == 0);
                cdb_tag[l]   = 3'($urandom);
                cdb_data[l]  = $urandom;
            end
            iss_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle_inputs();

        // asynchronous reset in the middle of a cycle
        drive_disp(mk(3'd5, 1, 3'd0, 32'h5, 1, 3'd0, 32'h5));
        cycle();
        cycle();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_iss_valid", 128'(iss_valid), 128'(0));
        check("async_rst_disp_ready", 128'(disp_ready), 128'(1));
        check("async_rst_occupancy", 128'(occupancy), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
